// File: rtl/gan_weight_loader.sv
// gan_weight_loader
// -----------------------------------------------------------------------------
// Streaming, double-buffered loader for the GAN parameter set. Parameter words
// arrive one per handshake. Each word is written into a shadow copy of the
// complete set. The four committed weight buses change only on an atomic
// commit, and a commit happens only after a complete, correctly framed stream.
// Because of this, the generator and discriminator keep running on the old set
// while a reload is in progress.
//
// Ports
//   clk, rst_n          : clock (rising edge); asynchronous active-low reset
//   s_valid/s_ready     : word stream handshake
//   s_data, s_last      : parameter word and end-of-stream marker
//   clear               : synchronous abort/acknowledge, returns to IDLE
//   flat_weights_L1/L2  : committed generator layer 1 / layer 2 buses
//   flat_weights_D1/D2  : committed discriminator layer 1 / layer 2 buses
//   weights_ready       : a committed set exists (sticky until reset)
//   commit_pulse        : one-cycle strobe, the cycle after a commit edge
//   load_error          : framing error; held until clear or reset
//   word_count          : words accepted in the current stream
//
// Handshake: a word transfers on a rising edge where s_valid && s_ready.
// s_data and s_last are sampled only on that edge. s_ready is combinational:
// it is high in every state except ERROR, and it is forced low while clear is
// asserted. s_ready does not depend on s_valid.
//
// Word k of a stream is stored at bits [k*WIDTH +: WIDTH] of one flat vector.
// The four output buses are consecutive slices of that vector, in the order
// L1, L2, D1, D2. As a result, slot j of each bus sits at bits [j*WIDTH +: WIDTH].
// -----------------------------------------------------------------------------
module gan_weight_loader #(
  parameter int WIDTH = 16,
  parameter int N_G1  = 9,
  parameter int N_G2  = 36,
  parameter int N_D1  = 30,
  parameter int N_D2  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_last,
  input  logic                   clear,
  output logic [N_G1*WIDTH-1:0]  flat_weights_L1,
  output logic [N_G2*WIDTH-1:0]  flat_weights_L2,
  output logic [N_D1*WIDTH-1:0]  flat_weights_D1,
  output logic [N_D2*WIDTH-1:0]  flat_weights_D2,
  output logic                   weights_ready,
  output logic                   commit_pulse,
  output logic                   load_error,
  output logic [6:0]             word_count
);

  localparam int N       = N_G1 + N_G2 + N_D1 + N_D2;
  localparam int TOTAL_W = N * WIDTH;
  localparam logic [6:0] LAST_IDX = 7'(N - 1);

  localparam int OFF_L2 = N_G1 * WIDTH;
  localparam int OFF_D1 = (N_G1 + N_G2) * WIDTH;
  localparam int OFF_D2 = (N_G1 + N_G2 + N_D1) * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TOTAL_W-1:0]   shadow_q, shadow_d;
  logic [TOTAL_W-1:0]   committed_q, committed_d;
  logic [6:0]           word_count_q, word_count_d;
  logic                 weights_ready_q, weights_ready_d;
  logic                 commit_pulse_q, commit_pulse_d;
  logic                 accept;

  assign s_ready = (state_q != ST_ERROR) && !clear;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d         = state_q;
    shadow_d        = shadow_q;
    committed_d     = committed_q;
    word_count_d    = word_count_q;
    weights_ready_d = weights_ready_q;
    commit_pulse_d  = 1'b0;

    if (clear) begin
      // Abort or acknowledge. The committed set and weights_ready stay as they are.
      state_d      = ST_IDLE;
      word_count_d = 7'd0;
    end else if (accept) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // A new stream starts. word_count restarts here even after DONE.
          shadow_d[0 +: WIDTH] = s_data;
          word_count_d         = 7'd1;
          state_d              = s_last ? ST_ERROR : ST_LOAD;
        end
        ST_LOAD: begin
          shadow_d[int'(word_count_q) * WIDTH +: WIDTH] = s_data;
          word_count_d = word_count_q + 7'd1;
          if (word_count_q == LAST_IDX) begin
            if (s_last) begin
              // shadow_d already holds the final word taken straight from
              // s_data, so the whole set commits on this same edge.
              committed_d     = shadow_d;
              weights_ready_d = 1'b1;
              commit_pulse_d  = 1'b1;
              state_d         = ST_DONE;
            end else begin
              state_d = ST_ERROR;
            end
          end else if (s_last) begin
            state_d = ST_ERROR;
          end
        end
        default: begin
          // ST_ERROR never accepts a word because s_ready is low there.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      shadow_q        <= '0;
      committed_q     <= '0;
      word_count_q    <= 7'd0;
      weights_ready_q <= 1'b0;
      commit_pulse_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      shadow_q        <= shadow_d;
      committed_q     <= committed_d;
      word_count_q    <= word_count_d;
      weights_ready_q <= weights_ready_d;
      commit_pulse_q  <= commit_pulse_d;
    end
  end

  assign flat_weights_L1 = committed_q[0      +: N_G1*WIDTH];
  assign flat_weights_L2 = committed_q[OFF_L2 +: N_G2*WIDTH];
  assign flat_weights_D1 = committed_q[OFF_D1 +: N_D1*WIDTH];
  assign flat_weights_D2 = committed_q[OFF_D2 +: N_D2*WIDTH];

  assign weights_ready = weights_ready_q;
  assign commit_pulse  = commit_pulse_q;
  assign load_error    = (state_q == ST_ERROR);
  assign word_count    = word_count_q;

endmodule

// File: doc/gan_weight_loader.md
# gan_weight_loader

Streaming weight loader that sits directly upstream of the generator and discriminator. It accepts the 79 signed 16-bit network parameters as a valid/ready word stream and packs them into the four flat weight buses those stages consume: Gen L1, Gen L2, Disc L1 and Disc L2. It double-buffers the set. Words land in shadow registers, and the output buses change only on an atomic commit after a complete, well-framed stream. This lets a reload proceed while the datapath keeps running on the previous set.

## Interface
- WIDTH, 16, parameter word width (Q-format agnostic, passed through bit-exact)
- N_G1, 9, Gen L1 parameter count
- N_G2, 36, Gen L2 parameter count
- N_D1, 30, Disc L1 parameter count
- N_D2, 4, Disc L2 parameter count (total N = 79)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- s_data  in  WIDTH  parameter word
- s_last  in  1  marks final word of a stream
- clear  in  1  synchronous abort/acknowledge; returns FSM to IDLE
- flat_weights_L1  out  N_G1*WIDTH  committed Gen L1 bus (144)
- flat_weights_L2  out  N_G2*WIDTH  committed Gen L2 bus (576)
- flat_weights_D1  out  N_D1*WIDTH  committed Disc L1 bus (480)
- flat_weights_D2  out  N_D2*WIDTH  committed Disc L2 bus (64)
- weights_ready  out  1  a committed set exists
- commit_pulse  out  1  one-cycle strobe on commit
- load_error  out  1  sticky framing error
- word_count  out  7  words accepted in current stream (0..79)

## Operation
- Handshake: word accepted when s_valid && s_ready at rising edge; s_data/s_last sampled only then.
- s_ready = (state ∈ {IDLE, LOAD, DONE}) && !clear; combinational.
- Index mapping for accepted word k (0-based within stream):
  - 0–8 → L1 slot k
  - 9–44 → L2 slot k-9
  - 45–74 → D1 slot k-45
  - 75–78 → D2 slot k-75
  - Slot j occupies bits [16j +: 16].
- FSM:
  - IDLE: accept → LOAD, word_count=1. If the word is word 0 with s_last=1, → ERROR.
  - LOAD: each accept writes the shadow slot and increments word_count.
    - s_last=1 on k<78 → ERROR.
    - k=78 with s_last=1 → commit, → DONE.
    - k=78 with s_last=0 → ERROR.
  - DONE: behaves as IDLE for a new stream. word_count reads 79 until the next accept, which sets it to 1.
  - ERROR: s_ready=0, load_error=1. Shadow contents are discarded (don't-care); committed buses are untouched. Exit only via clear or reset.
- clear (any state): → IDLE, word_count=0, load_error=0. The committed buses and weights_ready are unaffected. clear takes priority over a simultaneous s_valid, and no word is accepted that cycle.
- Commit: all four output buses load from shadow, with word 78 written directly from s_data in the same edge. weights_ready is set and stays set until reset. commit_pulse is high for exactly one cycle.
- A partial or failed reload never alters the committed buses.

## Timing
- Reset values: all buses 0, weights_ready=0, commit_pulse=0, load_error=0, word_count=0, state IDLE (so s_ready=1 after reset if clear=0).
- Throughput: one word per cycle; minimum load is 79 cycles.
- Latency: new buses, weights_ready and commit_pulse are visible the cycle after the final handshake edge.
- load_error rises the cycle after the offending handshake.
- s_valid gaps (bubbles) are allowed anywhere and do not affect state.
- Reset mid-load: immediate return to reset values; the committed set is lost.

## Test plan
- Nominal: stream words k+1 for k=0..78 (s_last on 79th) with s_valid held high → after 79 handshakes:
  - L1[15:0]=1, L2[15:0]=10, D1[15:0]=46, D2[63:48]=79.
  - weights_ready=1, commit_pulse high for exactly one cycle, word_count=79.
- Bubbles + negatives: same stream with s_valid toggling 50% and data -(k+1) → identical packing with 0xFFFF in L1 slot 0 and 0xFFB1 in D2 slot 3; commit occurs only after the 79th accept.
- Early last: after a valid commit of set A, send 41 words with s_last on word 40 → load_error=1, s_ready=0, buses still equal set A. Then clear → load_error=0, word_count=0, s_ready=1.
- Missing last: 79 words with no s_last → ERROR, no commit_pulse, buses unchanged.
- Reload atomicity: commit set A, then stream set B. Sample the buses every cycle → they equal A through the 78th accept of B and equal B from the cycle after the 79th accept.
- clear/reset corner: assert clear together with s_valid at word 20 → that word is not accepted and word_count=0. Then pulse rst_n low mid-load → all outputs at reset values while rst_n is low, regardless of clk.
